// File: rtl/sliding_window_pkg.sv
// Shared types and helpers for the sliding-window sequencer and its benches.
package sliding_window_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   // Offset from the window's bottom-right pixel back to its centre.
   function automatic int centre_off(input int n);
      return (n - 1) / 2;
   endfunction

   function automatic int win_per_frame(input int w, input int h, input int iw, input int ih);
      return (iw - w + 1) * (ih - h + 1);
   endfunction

endpackage

// File: rtl/sliding_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle of the sliding-window sequencer.
interface sliding_window_ctrl_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          in_valid;
   logic          in_sof;
   logic          in_ready;
   logic          shift_en;
   logic          win_valid;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic          out_ready;
   logic          frame_done;
   logic          frame_err;

   modport slave (
      input  in_valid, in_sof, out_ready,
      output in_ready, shift_en, win_valid, win_x, win_y, frame_done, frame_err
   );

   modport master (
      output in_valid, in_sof, out_ready,
      input  in_ready, shift_en, win_valid, win_x, win_y, frame_done, frame_err
   );
endinterface

// File: rtl/sliding_window_ctrl_px_coord_counter.sv
// Column/row position of the next pixel; load jumps to (1,0) because the
// loading pixel itself occupies (0,0).
module px_coord_counter #(
   parameter int IM_WIDTH  = 640,
   parameter int IM_HEIGHT = 480,
   localparam int XW = $clog2(IM_WIDTH),
   localparam int YW = $clog2(IM_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_i,
   input  logic          load_i,
   output logic [XW-1:0] col_o,
   output logic [YW-1:0] row_o,
   output logic          eol_o,
   output logic          eof_o
);
   localparam logic [XW-1:0] COL_LAST = XW'(IM_WIDTH - 1);
   localparam logic [YW-1:0] ROW_LAST = YW'(IM_HEIGHT - 1);

   logic [XW-1:0] col_q, col_d;
   logic [YW-1:0] row_q, row_d;

   assign eol_o = (col_q == COL_LAST);
   assign eof_o = eol_o & (row_q == ROW_LAST);
   assign col_o = col_q;
   assign row_o = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (load_i) begin
         col_d = XW'(1);
         row_d = '0;
      end else if (inc_i) begin
         if (eol_o) begin
            col_d = '0;
            row_d = eof_o ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end
endmodule

// File: rtl/sliding_window_ctrl.sv
// Sequencer for the pixel window and line-buffer chain: shift enable, position
// tracking, window-valid with centre coordinate, frame done/error pulses.
module sliding_window_ctrl
   import sliding_window_pkg::*;
#(
   parameter int W         = 9,
   parameter int H         = 9,
   parameter int IM_WIDTH  = 640,
   parameter int IM_HEIGHT = 480,
   localparam int XW = $clog2(IM_WIDTH),
   localparam int YW = $clog2(IM_HEIGHT)
) (
   input  logic clk,
   input  logic rst,
   sliding_window_ctrl_if.slave bus
);
   localparam logic [XW-1:0] COL_MIN = XW'(W - 1);
   localparam logic [YW-1:0] ROW_MIN = YW'(H - 1);
   localparam logic [XW-1:0] CX      = XW'(centre_off(W));
   localparam logic [YW-1:0] CY      = YW'(centre_off(H));

   state_e        state_q, state_d;
   logic          win_valid_q;
   logic [XW-1:0] win_x_q;
   logic [YW-1:0] win_y_q;
   logic          frame_done_q, frame_done_d;
   logic          frame_err_q, frame_err_d;

   logic          in_ready, acc, shift_en;
   logic          cnt_inc, cnt_load, win_hit;
   logic [XW-1:0] col;
   logic [YW-1:0] row;
   logic          eol, eof;

   px_coord_counter #(.IM_WIDTH(IM_WIDTH), .IM_HEIGHT(IM_HEIGHT)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (cnt_inc),
      .load_i (cnt_load),
      .col_o  (col),
      .row_o  (row),
      .eol_o  (eol),
      .eof_o  (eof)
   );

   assign in_ready = (state_q == IDLE) |
                     ((state_q == RUN) & (~win_valid_q | bus.out_ready));
   assign acc      = bus.in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      shift_en     = 1'b0;
      cnt_inc      = 1'b0;
      cnt_load     = 1'b0;
      win_hit      = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc & bus.in_sof) begin
               shift_en = 1'b1;
               cnt_load = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (acc) begin
               shift_en = 1'b1;
               // A premature sof restarts the frame; the pending window stays.
               if (bus.in_sof) begin
                  cnt_load    = 1'b1;
                  frame_err_d = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
                  win_hit = (col >= COL_MIN) & (row >= ROW_MIN);
                  if (eof) state_d = DONE;
               end
            end
         end
         DONE: begin
            if (~win_valid_q | bus.out_ready) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         win_valid_q  <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         if (win_hit) begin
            win_valid_q <= 1'b1;
            win_x_q     <= col - CX;
            win_y_q     <= row - CY;
         end else if (win_valid_q & bus.out_ready) begin
            win_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.shift_en   = shift_en;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_x      = win_x_q;
   assign bus.win_y      = win_y_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Directed bench for sliding_window_ctrl on an 8x4 frame with a 3x3 window.
module tb_sliding_window_ctrl;
   import sliding_window_pkg::*;

   localparam int W = 3, H = 3, IW = 8, IH = 4;
   localparam int XW = $clog2(IW), YW = $clog2(IH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sliding_window_ctrl_if #(.XW(XW), .YW(YW)) bus ();

   sliding_window_ctrl #(.W(W), .H(H), .IM_WIDTH(IW), .IM_HEIGHT(IH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0, errors = 0;
   int n_shift = 0, n_win = 0, n_fd = 0, n_fe = 0;

   always @(negedge clk) begin
      if (!rst) begin
         n_shift += int'(bus.shift_en);
         n_win   += int'(bus.win_valid & bus.out_ready);
         n_fd    += int'(bus.frame_done);
         n_fe    += int'(bus.frame_err);
      end
   end

   typedef struct {
      int   n;
      logic v, s, o;
      logic ir, se, wv, fd, fe;
      int   wx, wy;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic s, input logic o);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_sof    = s;
      bus.out_ready = o;
      @(negedge clk);
      #1;
   endtask

   task automatic chk_pos(input string nm, input int x, input int y);
      chk({nm, ".wv"}, 32'(bus.win_valid), 32'd1);
      chk({nm, ".wx"}, 32'(bus.win_x), 32'(x));
      chk({nm, ".wy"}, 32'(bus.win_y), 32'(y));
   endtask

   vec_t tbl[19];
   int   b_shift, b_win, b_fd, b_fe, g;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      // in_valid, in_sof, out_ready; expected in_ready, shift_en, win_valid, frame_done, frame_err, win_x, win_y
      tbl = '{
         '{2, 1,0,1, 1,0,0,0,0, -1,-1},   // non-sof pixels in IDLE are dropped
         '{1, 0,0,1, 1,0,0,0,0, -1,-1},
         '{1, 1,1,1, 1,1,0,0,0, -1,-1},   // pixel 0
         '{18,1,0,1, 1,1,0,0,0, -1,-1},   // pixels 1..18
         '{1, 1,0,1, 1,1,1,0,0,  1, 1},   // pixel 19 sees window from pixel 18
         '{1, 1,0,1, 1,1,1,0,0,  2, 1},
         '{1, 1,0,1, 1,1,1,0,0,  3, 1},
         '{1, 1,0,1, 1,1,1,0,0,  4, 1},
         '{1, 1,0,1, 1,1,1,0,0,  5, 1},
         '{1, 1,0,1, 1,1,1,0,0,  6, 1},   // pixel 24
         '{2, 1,0,1, 1,1,0,0,0, -1,-1},   // line wrap: no window
         '{1, 1,0,1, 1,1,1,0,0,  1, 2},   // pixel 27
         '{1, 1,0,1, 1,1,1,0,0,  2, 2},
         '{1, 1,0,1, 1,1,1,0,0,  3, 2},
         '{1, 1,0,1, 1,1,1,0,0,  4, 2},
         '{1, 1,0,1, 1,1,1,0,0,  5, 2},   // pixel 31
         '{1, 0,0,1, 0,0,1,0,0,  6, 2},   // DONE
         '{1, 0,0,1, 1,0,0,1,0, -1,-1},   // frame_done pulse in IDLE
         '{1, 0,0,1, 1,0,0,0,0, -1,-1}
      };

      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) cyc(0, 0, 0);
      chk("rst.ir", 32'(bus.in_ready), 32'd1);
      chk("rst.wv", 32'(bus.win_valid), 32'd0);
      chk("rst.wx", 32'(bus.win_x), 32'd0);
      chk("rst.wy", 32'(bus.win_y), 32'd0);
      chk("rst.fd", 32'(bus.frame_done), 32'd0);
      chk("rst.fe", 32'(bus.frame_err), 32'd0);
      rst = 1'b0;

      // Frame 1: continuous stream, consumer always ready
      b_shift = n_shift; b_win = n_win; b_fd = n_fd; b_fe = n_fe;
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].o);
            chk($sformatf("tbl%0d.%0d.ir", i, k), 32'(bus.in_ready), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d.%0d.se", i, k), 32'(bus.shift_en), 32'(tbl[i].se));
            chk($sformatf("tbl%0d.%0d.wv", i, k), 32'(bus.win_valid), 32'(tbl[i].wv));
            chk($sformatf("tbl%0d.%0d.fd", i, k), 32'(bus.frame_done), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d.%0d.fe", i, k), 32'(bus.frame_err), 32'(tbl[i].fe));
            if (tbl[i].wx >= 0) begin
               chk($sformatf("tbl%0d.%0d.wx", i, k), 32'(bus.win_x), 32'(tbl[i].wx));
               chk($sformatf("tbl%0d.%0d.wy", i, k), 32'(bus.win_y), 32'(tbl[i].wy));
            end
         end
      end
      chk("f1.shifts", 32'(n_shift - b_shift), 32'd32);
      chk("f1.windows", 32'(n_win - b_win), 32'd12);
      chk("f1.done", 32'(n_fd - b_fd), 32'd1);
      chk("f1.err", 32'(n_fe - b_fe), 32'd0);

      // Backpressure: consumer stalls 5 cycles on the first window
      b_shift = n_shift; b_win = n_win; b_fd = n_fd;
      cyc(1, 1, 1);
      repeat (18) cyc(1, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 0);
         chk($sformatf("bp%0d.ir", k), 32'(bus.in_ready), 32'd0);
         chk($sformatf("bp%0d.se", k), 32'(bus.shift_en), 32'd0);
         chk_pos($sformatf("bp%0d", k), 1, 1);
      end
      cyc(1, 0, 1);
      chk("bp.release.se", 32'(bus.shift_en), 32'd1);
      g = 0;
      while ((n_shift - b_shift) < 32 && g < 100) begin
         cyc(1, 0, 1);
         g++;
      end
      chk("bp.accept_bound", 32'(g < 100), 32'd1);
      repeat (3) cyc(0, 0, 1);
      chk("bp.shifts", 32'(n_shift - b_shift), 32'd32);
      chk("bp.windows", 32'(n_win - b_win), 32'd12);
      chk("bp.done", 32'(n_fd - b_fd), 32'd1);

      // Premature sof at pixel index 20
      b_fd = n_fd; b_fe = n_fe;
      cyc(1, 1, 1);
      repeat (19) cyc(1, 0, 1);
      cyc(1, 1, 1);
      chk("abort.se", 32'(bus.shift_en), 32'd1);
      chk("abort.fe0", 32'(bus.frame_err), 32'd0);
      cyc(1, 0, 1);
      chk("abort.fe1", 32'(bus.frame_err), 32'd1);
      repeat (17) cyc(1, 0, 1);
      chk("abort.pre.wv", 32'(bus.win_valid), 32'd0);
      cyc(1, 0, 1);
      chk_pos("abort.win", 1, 1);
      cyc(0, 0, 1);
      chk("abort.fe_count", 32'(n_fe - b_fe), 32'd1);
      chk("abort.fd_count", 32'(n_fd - b_fd), 32'd0);

      // Reset mid-frame while a window is held
      rst = 1'b1;
      cyc(0, 0, 1);
      rst = 1'b0;
      cyc(1, 1, 1);
      repeat (23) cyc(1, 0, 1);
      cyc(1, 0, 0);
      chk("rstmid.pre.ir", 32'(bus.in_ready), 32'd0);
      chk_pos("rstmid.pre", 6, 1);
      rst = 1'b1;
      cyc(1, 0, 0);
      chk("rstmid.wv", 32'(bus.win_valid), 32'd0);
      chk("rstmid.ir", 32'(bus.in_ready), 32'd1);
      chk("rstmid.wx", 32'(bus.win_x), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 1);
         chk($sformatf("rstmid.ign%0d.se", k), 32'(bus.shift_en), 32'd0);
         chk($sformatf("rstmid.ign%0d.ir", k), 32'(bus.in_ready), 32'd1);
      end

      // Last window pending at frame end with consumer stalled
      b_fd = n_fd;
      cyc(1, 1, 1);
      chk("end.sof.se", 32'(bus.shift_en), 32'd1);
      repeat (30) cyc(1, 0, 1);
      cyc(1, 0, 1);
      chk("end.p31.se", 32'(bus.shift_en), 32'd1);
      chk_pos("end.p31", 5, 2);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0);
         chk($sformatf("end.hold%0d.ir", k), 32'(bus.in_ready), 32'd0);
         chk($sformatf("end.hold%0d.fd", k), 32'(bus.frame_done), 32'd0);
         chk_pos($sformatf("end.hold%0d", k), 6, 2);
      end
      cyc(1, 1, 1);
      chk("end.rel.ir", 32'(bus.in_ready), 32'd0);
      chk("end.rel.se", 32'(bus.shift_en), 32'd0);
      chk("end.rel.fd", 32'(bus.frame_done), 32'd0);
      cyc(1, 1, 1);
      chk("end.fd", 32'(bus.frame_done), 32'd1);
      chk("end.ir", 32'(bus.in_ready), 32'd1);
      chk("end.se", 32'(bus.shift_en), 32'd1);
      chk("end.wv", 32'(bus.win_valid), 32'd0);
      cyc(0, 0, 1);
      chk("end.fd_off", 32'(bus.frame_done), 32'd0);
      chk("end.fd_count", 32'(n_fd - b_fd), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
